// File: rtl/gpi_debounce_chan.sv
// One input channel: synchroniser, optional inversion and stable-count
// debouncer producing a clean level and one-cycle edge pulses.
module gpi_debounce_chan #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 100000,
  parameter bit          Invert         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  s;
  logic                  flip;

  assign s    = sync_q[SyncStages-1] ^ Invert;
  assign flip = (s != level) && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SyncStages{Invert}};
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], raw};
      rise   <= flip & s;
      fall   <= flip & ~s;
      // counter tops out at CntLast, so it never wraps
      if (s == level || flip) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (flip) begin
        level <= s;
      end
    end
  end

endmodule

// File: rtl/gpi_debounce.sv
// Debounced general-purpose inputs with per-channel pending bits,
// lowest-index arbitration and an edge-event FIFO.
module gpi_debounce #(
  parameter int unsigned          NumInputs      = 8,
  parameter int unsigned          SyncStages     = 2,
  parameter int unsigned          DebounceCycles = 100000,
  parameter logic [NumInputs-1:0] InvertMask     = '0,
  parameter int unsigned          EventDepth     = 4,
  localparam int unsigned IdxW = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic [NumInputs-1:0] gp_raw_i,
  output logic [NumInputs-1:0] gp_o,
  output logic [NumInputs-1:0] rise_o,
  output logic [NumInputs-1:0] fall_o,
  output logic                 event_valid_o,
  input  logic                 event_ready_i,
  output logic [IdxW-1:0]      event_idx_o,
  output logic                 event_rise_o,
  output logic                 overflow_o,
  input  logic                 overflow_clr_i
);

  localparam int unsigned PtrW = $clog2(EventDepth);

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic            rise;
  } event_t;

  for (genvar i = 0; i < NumInputs; i++) begin : g_chan
    gpi_debounce_chan #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles),
      .Invert         (InvertMask[i])
    ) u_chan (
      .clk   (clk_sys_i),
      .rst_n (rst_sys_ni),
      .raw   (gp_raw_i[i]),
      .level (gp_o[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i])
    );
  end

  logic [NumInputs-1:0] edge_d;
  logic [NumInputs-1:0] pend_q, pend_d;
  logic [NumInputs-1:0] dir_q, dir_d;
  logic [NumInputs-1:0] grant_oh;
  logic [IdxW-1:0]      grant_idx;
  logic                 grant_any;
  logic                 ovf_set;

  logic [PtrW:0] wr_q, rd_q, count;
  event_t        mem_q [EventDepth];
  event_t        head;
  logic          full, empty, push, pop;

  assign count = wr_q - rd_q;
  assign full  = (count == (PtrW+1)'(EventDepth));
  assign empty = (wr_q == rd_q);
  assign pop   = !empty && event_ready_i;
  assign push  = grant_any && (!full || pop);
  assign head  = mem_q[rd_q[PtrW-1:0]];

  assign event_valid_o = !empty;
  assign event_idx_o   = head.idx;
  assign event_rise_o  = head.rise;

  assign edge_d = rise_o | fall_o;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = int'(NumInputs) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_any = 1'b1;
        grant_idx = IdxW'(i);
      end
    end
  end

  // a fresh edge re-arms pending even on the cycle its old event is pushed
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < int'(NumInputs); i++) begin
      grant_oh[i] = push && (grant_idx == IdxW'(i));
    end
    pend_d  = edge_d | (pend_q & ~grant_oh);
    dir_d   = rise_o | (dir_q & ~edge_d);
    ovf_set = |(edge_d & pend_q & ~grant_oh);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pend_q     <= '0;
      dir_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_o <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dir_q  <= dir_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end else if (overflow_clr_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (push) begin
      mem_q[wr_q[PtrW-1:0]] <= '{idx: grant_idx, rise: dir_q[grant_idx]};
    end
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Randomised and directed bench for gpi_debounce against a history-window
// and queue based reference model.
module tb_gpi_debounce;

  localparam int N   = 8;
  localparam int SS  = 2;
  localparam int D   = 4;
  localparam int DEP = 4;
  localparam logic [7:0] INV = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gp_raw;
  logic       ready;
  logic       clr;
  logic [7:0] gp, rise, fall;
  logic       ev_valid;
  logic [2:0] ev_idx;
  logic       ev_rise;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpi_debounce #(
    .NumInputs      (N),
    .SyncStages     (SS),
    .DebounceCycles (D),
    .InvertMask     (INV),
    .EventDepth     (DEP)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_n),
    .gp_raw_i       (gp_raw),
    .gp_o           (gp),
    .rise_o         (rise),
    .fall_o         (fall),
    .event_valid_o  (ev_valid),
    .event_ready_i  (ready),
    .event_idx_o    (ev_idx),
    .event_rise_o   (ev_rise),
    .overflow_o     (ovf),
    .overflow_clr_i (clr)
  );

  // reference model: level flips once the synchronised pin has disagreed
  // with it for D consecutive samples; events are plain queues
  logic [7:0] m_gp, m_rise, m_fall, m_pend, m_dir;
  logic       m_ovf;
  logic [3:0] mq[$];
  logic [7:0] hist[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] flip;
    logic [7:0] smp;
    logic       oset;
    int         g;
    if (!rst_n) begin
      hist = {};
      repeat (SS + D) hist.push_back(INV);
      m_gp = 0; m_rise = 0; m_fall = 0;
      m_pend = 0; m_dir = 0; m_ovf = 0;
      mq = {};
    end else begin
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      g = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) g = i;
      if (g >= 0 && mq.size() < DEP) begin
        mq.push_back({3'(g), m_dir[g]});
        m_pend[g] = 1'b0;
      end
      oset = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_rise[i] || m_fall[i]) begin
          if (m_pend[i]) oset = 1'b1;
          m_pend[i] = 1'b1;
          m_dir[i]  = m_rise[i];
        end
      end
      if (oset) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      hist.push_back(gp_raw);
      if (hist.size() > SS + D) void'(hist.pop_front());
      flip = 8'hFF;
      for (int j = 0; j < D; j++) begin
        smp = hist[hist.size() - 1 - SS - j] ^ INV;
        flip = flip & (smp ^ m_gp);
      end
      m_rise = flip & ~m_gp;
      m_fall = flip & m_gp;
      m_gp   = m_gp ^ flip;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; gp_raw = INV; ready = 1'b0; clr = 1'b0;
    cyc(3);
    n_tests++;
    if (gp !== 8'h00 || rise !== 8'h00 || fall !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_levels got gp=%h r=%h f=%h want 00", gp, rise, fall);
    end
    rst_n = 1'b1;
    cyc(10);
    n_tests++;
    if (gp !== 8'h00 || gp !== m_gp) begin
      n_fail++; $display("FAIL idle_gp got %h want 00", gp);
    end
    n_tests++;
    if ((rise | fall) !== 8'h00) begin
      n_fail++; $display("FAIL idle_pulse got %h want 00", rise | fall);
    end
    n_tests++;
    if (ev_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_fifo got v=%b o=%b want 0 0", ev_valid, ovf);
    end
  endtask

  task automatic test_step;
    int lat = 0;
    gp_raw[3] = 1'b1;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (gp[3] === 1'b1) lat = k;
    end
    n_tests++;
    if (lat != SS + D) begin
      n_fail++; $display("FAIL step_latency got %0d want %0d", lat, SS + D);
    end
    n_tests++;
    if (rise !== 8'h08 || rise !== m_rise) begin
      n_fail++; $display("FAIL step_rise got %h want 08", rise);
    end
    cyc(1);
    n_tests++;
    if (rise !== 8'h00) begin
      n_fail++; $display("FAIL step_rise_width got %h want 00", rise);
    end
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (ev_valid !== 1'b1 || ev_idx !== 3'd3 || ev_rise !== 1'b1) begin
        n_fail++;
        $display("FAIL step_head got v=%b idx=%0d r=%b want 1 3 1",
                 ev_valid, ev_idx, ev_rise);
      end
      cyc(1);
    end
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    n_tests++;
    if (ev_valid !== 1'b0) begin
      n_fail++; $display("FAIL step_pop got v=%b want 0", ev_valid);
    end
  endtask

  task automatic test_glitch;
    int nr = 0;
    int nf = 0;
    logic [3:0] exp_ev [2];
    gp_raw[5] = 1'b1;
    cyc(3);
    gp_raw[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      n_tests++;
      if (gp[5] !== 1'b0 || rise[5] !== 1'b0 || fall[5] !== 1'b0 ||
          ev_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_short got gp=%b r=%b f=%b v=%b want 0 0 0 0",
                 gp[5], rise[5], fall[5], ev_valid);
      end
    end
    gp_raw[5] = 1'b1;
    cyc(4);
    gp_raw[5] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      nr += int'(rise[5]);
      nf += int'(fall[5]);
    end
    n_tests++;
    if (nr != 1 || nf != 1) begin
      n_fail++; $display("FAIL glitch_long got rises=%0d falls=%0d want 1 1", nr, nf);
    end
    exp_ev[0] = {3'd5, 1'b1};
    exp_ev[1] = {3'd5, 1'b0};
    for (int e = 0; e < 2; e++) begin
      n_tests++;
      if (ev_valid !== 1'b1 || {ev_idx, ev_rise} !== exp_ev[e]) begin
        n_fail++;
        $display("FAIL glitch_event%0d got v=%b ev=%h want 1 %h",
                 e, ev_valid, {ev_idx, ev_rise}, exp_ev[e]);
      end
      ready = 1'b1;
      cyc(1);
      ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got[$];
    int         at[$];
    ready = 1'b1;
    gp_raw[1] = 1'b1;
    gp_raw[6] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (ev_valid === 1'b1) begin
        got.push_back({ev_idx, ev_rise});
        at.push_back(k);
      end
    end
    ready = 1'b0;
    n_tests++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL b2b_count got %0d want 2", got.size());
    end else begin
      n_tests++;
      if (got[0] !== {3'd1, 1'b1} || got[1] !== {3'd6, 1'b1}) begin
        n_fail++; $display("FAIL b2b_order got %h %h want 3 d", got[0], got[1]);
      end
      n_tests++;
      if (at[1] != at[0] + 1) begin
        n_fail++; $display("FAIL b2b_gap got %0d want 1", at[1] - at[0]);
      end
    end
  endtask

  task automatic test_overflow;
    int         perm[8];
    logic [7:0] mask = 8'h00;
    int         hi = 0;
    int         drained = 0;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 5; i++) mask[perm[i]] = 1'b1;
    for (int i = 0; i < 8; i++) if (mask[i]) hi = i;
    gp_raw = gp_raw ^ mask;
    cyc(12);
    n_tests++;
    if (ev_valid !== 1'b1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill got v=%b o=%b want 1 0", ev_valid, ovf);
    end
    n_tests++;
    if ({ev_idx, ev_rise} !== mq[0]) begin
      n_fail++; $display("FAIL ovf_head got %h want %h", {ev_idx, ev_rise}, mq[0]);
    end
    gp_raw[hi] = ~gp_raw[hi];
    cyc(10);
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set ch%0d got %b want 1", hi, ovf);
    end
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr got %b want 0", ovf);
    end
    ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (ev_valid === 1'b1) begin
        drained++;
        n_tests++;
        if (mq.size() == 0 || {ev_idx, ev_rise} !== mq[0]) begin
          n_fail++; $display("FAIL ovf_drain got %h", {ev_idx, ev_rise});
        end
      end
      cyc(1);
    end
    ready = 1'b0;
    n_tests++;
    if (drained != 5) begin
      n_fail++; $display("FAIL ovf_drained got %0d want 5", drained);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) gp_raw[$urandom_range(0, 7)] ^= 1'b1;
      ready = ($urandom_range(0, 1) == 1);
      clr   = ($urandom_range(0, 15) == 0);
      cyc(1);
      n_tests++;
      if (gp !== m_gp) begin
        n_fail++; $display("FAIL rnd_gp @%0d got %h want %h", k, gp, m_gp);
      end
      n_tests++;
      if ({rise, fall} !== {m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL rnd_pulse @%0d got %h/%h want %h/%h",
                 k, rise, fall, m_rise, m_fall);
      end
      n_tests++;
      if (ev_valid !== (mq.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid @%0d got %b want %b", k, ev_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_tests++;
        if ({ev_idx, ev_rise} !== mq[0]) begin
          n_fail++; $display("FAIL rnd_head @%0d got %h want %h", k, {ev_idx, ev_rise}, mq[0]);
        end
      end
      n_tests++;
      if (ovf !== m_ovf) begin
        n_fail++; $display("FAIL rnd_ovf @%0d got %b want %b", k, ovf, m_ovf);
      end
    end
    ready = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_invert_reset;
    int lat = 0;
    rst_n  = 1'b0;
    gp_raw = 8'h01;
    ready  = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    n_tests++;
    if (gp !== 8'h00) begin
      n_fail++; $display("FAIL inv_idle got %h want 00", gp);
    end
    gp_raw[0] = 1'b0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (gp[0] === 1'b1) lat = k;
    end
    n_tests++;
    if (lat != SS + D) begin
      n_fail++; $display("FAIL inv_latency got %0d want %0d", lat, SS + D);
    end
    gp_raw[2] = 1'b1;
    gp_raw[4] = 1'b1;
    cyc(12);
    n_tests++;
    if (ev_valid !== 1'b1) begin
      n_fail++; $display("FAIL inv_queue got %b want 1", ev_valid);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ev_valid !== 1'b0 || gp !== 8'h00 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got v=%b gp=%h o=%b want 0 00 0", ev_valid, gp, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    n_tests++;
    if (ev_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got %b want 0", ev_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_step();
    test_glitch();
    test_back_to_back();
    test_overflow();
    test_random();
    test_invert_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
